adc733_seq_ctrl: RTL

// Sequencer and sample collector for the ADC733 serial-port controller. It holds the
// 8 ADC register words plus the final data-mode word, issues the one-shot sync, and

---
 rtl/adc733_seq_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/adc733_seq_ctrl.sv
// ADC733 serial-port sequencer: plays out the register table after a one-shot sync,
// then collects per-channel samples into a bank and flags completed frames.
module adc733_seq_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int NUM_CH   = 6,
    parameter int DW       = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          start,
    input  logic          abort,
    output logic          sync,
    output logic [DW-1:0] control_word,
    input  logic          word_sent,
    input  logic          rd_en,
    input  logic [2:0]    channel,
    input  logic [DW-1:0] captured_data,
    input  logic [2:0]    rd_ch,
    output logic [DW-1:0] rd_data,
    output logic          frame_valid,
    output logic [15:0]   frame_cnt,
    output logic          cfg_done,
    output logic          busy,
    output logic [1:0]    err
);

    // Handshake: start, abort, word_sent and rd_en are single-cycle pulses, sampled
    // on the rising edge they are high; consecutive-cycle pulses count separately.
    // channel/captured_data are qualified by rd_en only. sync and frame_valid are
    // single-cycle pulses produced from registers.

    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_CFG  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [3:0]    LAST_IDX = 4'(NUM_REGS);
    localparam logic [2:0]    CH_LIM   = 3'(NUM_CH);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    logic [2:0]        state;
    logic [3:0]        word_idx;
    logic [TW-1:0]     to_cnt;
    logic [NUM_CH-1:0] seen;
    logic [DW-1:0]     cfg_table [0:NUM_REGS];
    logic [DW-1:0]     bank      [0:NUM_CH-1];

    logic [3:0]        load_idx;
    logic [DW-1:0]     load_word;
    logic              ch_ok;
    logic              store_en;
    logic [NUM_CH-1:0] ch_onehot;
    logic [NUM_CH-1:0] seen_next;

    assign busy     = (state != S_IDLE);
    assign cfg_done = (state == S_RUN);

    assign ch_ok     = (channel < CH_LIM);
    assign store_en  = (state == S_RUN) && rd_en && !abort && ch_ok;
    assign ch_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << channel;
    assign seen_next = seen | ch_onehot;

    // Index of the word that control_word should hold after this edge.
    always_comb begin
        load_idx = word_idx;
        if (state == S_ARM) begin
            load_idx = 4'd0;
        end else if ((state == S_CFG) && word_sent && (word_idx != LAST_IDX)) begin
            load_idx = word_idx + 4'd1;
        end
    end

    // A same-cycle table write is forwarded so the new word shows up one cycle later.
    always_comb begin
        load_word = cfg_table[load_idx];
        if (cfg_we && (cfg_addr == load_idx)) begin
            load_word = cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NUM_REGS; i++) begin
                cfg_table[i] <= '0;
            end
        end else if (cfg_we && (cfg_addr <= LAST_IDX)) begin
            cfg_table[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            control_word <= '0;
        end else if (!abort && ((state == S_ARM) || (state == S_CFG) || (state == S_RUN))) begin
            control_word <= load_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bank[i] <= '0;
            end
        end else if (store_en) begin
            bank[channel] <= captured_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_ch < CH_LIM) begin
            rd_data <= bank[rd_ch];
        end else begin
            rd_data <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            word_idx    <= '0;
            to_cnt      <= '0;
            seen        <= '0;
            sync        <= 1'b0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            err         <= '0;
        end else begin
            sync        <= 1'b0;
            frame_valid <= 1'b0;
            if (abort) begin
                state    <= S_IDLE;
                word_idx <= '0;
                to_cnt   <= '0;
                seen     <= '0;
                err      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state    <= S_ARM;
                            word_idx <= '0;
                            to_cnt   <= '0;
                            sync     <= 1'b1;
                        end
                    end
                    S_ARM: begin
                        state  <= S_CFG;
                        to_cnt <= '0;
                    end
                    S_CFG: begin
                        if (word_sent) begin
                            to_cnt <= '0;
                            if (word_idx == LAST_IDX) begin
                                state <= S_RUN;
                                seen  <= '0;
                            end else begin
                                word_idx <= word_idx + 4'd1;
                            end
                        end else if (to_cnt == TO_LAST) begin
                            state  <= S_ERR;
                            err[0] <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + TO_ONE;
                        end
                    end
                    S_RUN: begin
                        if (rd_en) begin
                            to_cnt <= '0;
                            if (!ch_ok) begin
                                err[1] <= 1'b1;
                            end else if (&seen_next) begin
                                // Completing sample is already in the bank; next rd_en opens a new frame.
                                seen        <= '0;
                                frame_valid <= 1'b1;
                                frame_cnt   <= frame_cnt + 16'd1;
                            end else begin
                                seen <= seen_next;
                            end
                        end else if (to_cnt == TO_LAST) begin
                            state  <= S_ERR;
                            err[0] <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + TO_ONE;
                        end
                    end
                    S_ERR: begin
                        state <= S_ERR;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
